multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Multi-cycle RV32I control unit; supersedes the single-cycle opcode decoder. A state machine sequences FETCH/DECODE/EXECUTE/MEM/WB and drives datapath mux selects, write enables and a memory request handshake. Adds JAL, JALR, LUI and AUIPC, variable-latency memory via a mem_ready handshake, a memory timeout and illegal-opcode trapping. Sits between the instruction register (IR) and the shared-memory multi-cycle datapath.

Parameters:
MEM_TIMEOUT, 15, consecutive cycles without mem_ready before bus_err; 0 disables the timeout.
EN_UPPER, 1, 1 = LUI/AUIPC legal; 0 = these opcodes trap as illegal.
EN_JUMP, 1, 1 = JAL/JALR legal; 0 = these opcodes trap as illegal.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
opcode  in  7  IR[6:0]; stable from DECODE until the next FETCH
mem_ready  in  1  memory completed the current request this cycle
branch_taken  in  1  datapath branch-compare result, valid in EXECUTE
mem_req  out  1  memory request
mem_we  out  1  store when mem_req=1
ir_write  out  1  load IR
pc_write  out  1  update PC
reg_write  out  1  register-file write
alu_src_a  out  2  00 PC, 01 OLDPC, 10 RS1
alu_src_b  out  2  00 RS2, 01 IMM, 10 CONST4
alu_op  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
wb_sel  out  2  00 ALUOUT, 01 MEMDATA, 10 PC, 11 IMM
pc_src  out  1  0 live ALU result, 1 ALUOUT register
illegal_instr  out  1  sticky flag: illegal opcode
bus_err  out  1  sticky flag: memory timeout
state_dbg  out  3  current state encoding

Behaviour:
- Reset: state is set to FETCH. While rst_n=0, all outputs are forced to 0 and the sticky flags and wait counter are cleared. Reset mid-operation aborts the instruction; no partial writes occur after rst_n falls.
- Outputs are combinational from state, opcode, mem_ready and branch_taken. Any unlisted output is 0 in that state.
- FETCH: mem_req=1, alu_src_a=PC, alu_src_b=CONST4, alu_op=00.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=OLDPC, alu_src_b=IMM, alu_op=00; the datapath latches the branch/JAL target into ALUOUT.
  - Illegal opcode: next state TRAP and illegal_instr is set.
  - Legal opcode: next state EXECUTE.
- EXECUTE, by opcode:
  - R 0110011: RS1/RS2, alu_op=10, next WB.
  - I-ALU 0010011: RS1/IMM, alu_op=11, next WB.
  - Load 0000011 / Store 0100011: RS1/IMM, alu_op=00, next MEM.
  - Branch 1100011: RS1/RS2, alu_op=01. If branch_taken=1: pc_write=1, pc_src=1. Next FETCH.
  - JAL 1101111: pc_write=1, pc_src=1, reg_write=1, wb_sel=PC (holds pc+4). Next FETCH.
  - JALR 1100111: RS1/IMM, alu_op=00, pc_write=1, pc_src=0, reg_write=1, wb_sel=PC. Next FETCH.
  - LUI 0110111: reg_write=1, wb_sel=IMM. Next FETCH.
  - AUIPC 0010111: OLDPC/IMM, alu_op=00. Next WB.
- MEM: mem_req=1, mem_we=1 for store.
  - On mem_ready: load goes to WB, store goes to FETCH.
  - Otherwise stay in MEM.
- WB: reg_write=1; wb_sel=MEMDATA for load, ALUOUT otherwise. Next FETCH.
- TRAP: all control outputs 0, flags held, stays until reset.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and increments each cycle mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready=0: bus_err is set and the next state is TRAP.
  - If mem_ready=1 in the same cycle, mem_ready wins.
  - The counter width is clog2(MEM_TIMEOUT+1); the counter saturates and never wraps.
- CPI with zero-wait memory: R/I/AUIPC 4, load 5, store 4, branch/JAL/JALR/LUI 3. Each memory wait cycle adds 1.

Decomposition:
- Package rv_ctrl_pkg holds: opcode localparams, the state encoding (FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=7), and all mux-select encodings listed above.
- One combinational sub-module, rv_opcode_class: opcode plus EN_* parameters in, one-hot class and illegal out.

Test Plan:
- add (0110011), mem_ready tied 1 -> states 0,1,2,4,0; reg_write only in WB with alu_op=10; instruction takes 4 cycles.
- lw with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles with mem_we=0; WB has wb_sel=01; total 8 cycles.
- beq: branch_taken=1 -> pc_write=1, pc_src=1 in EXECUTE. branch_taken=0 -> pc_write=0. Both cases reach the next FETCH after 3 cycles.
- jal -> EXECUTE asserts pc_write, reg_write and wb_sel=10 in the same cycle; next state FETCH.
- opcode 1111111, and LUI with EN_UPPER=0 -> TRAP, illegal_instr=1 held; rst_n=0 for 1 cycle returns to FETCH with flags 0.
- MEM_TIMEOUT=15 with mem_ready stuck at 0 in FETCH -> bus_err after 15 wait cycles, then TRAP. mem_ready=1 on exactly that cycle -> normal DECODE with no error.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// datapath mux selects and the packed control-word bundle.
package rv_ctrl_pkg;

    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned NUM_CLASS = 9;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

    // Bit positions inside the one-hot instruction class vector
    localparam int unsigned CLS_R      = 0;
    localparam int unsigned CLS_I      = 1;
    localparam int unsigned CLS_LOAD   = 2;
    localparam int unsigned CLS_STORE  = 3;
    localparam int unsigned CLS_BRANCH = 4;
    localparam int unsigned CLS_JAL    = 5;
    localparam int unsigned CLS_JALR   = 6;
    localparam int unsigned CLS_LUI    = 7;
    localparam int unsigned CLS_AUIPC  = 8;

    typedef logic [NUM_CLASS-1:0] op_class_t;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd7
    } state_e;

    localparam logic [SEL_W-1:0] SRCA_PC     = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1    = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_CONST4 = 2'b10;

    localparam logic [SEL_W-1:0] ALU_ADD     = 2'b00;
    localparam logic [SEL_W-1:0] ALU_BRANCH  = 2'b01;
    localparam logic [SEL_W-1:0] ALU_RTYPE   = 2'b10;
    localparam logic [SEL_W-1:0] ALU_ITYPE   = 2'b11;

    localparam logic [SEL_W-1:0] WB_ALUOUT   = 2'b00;
    localparam logic [SEL_W-1:0] WB_MEMDATA  = 2'b01;
    localparam logic [SEL_W-1:0] WB_PC       = 2'b10;
    localparam logic [SEL_W-1:0] WB_IMM      = 2'b11;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    typedef struct packed {
        logic             mem_req;
        logic             mem_we;
        logic             ir_write;
        logic             pc_write;
        logic             reg_write;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] wb_sel;
        logic             pc_src;
    } ctrl_t;

endpackage

// File: rtl/rv_opcode_class.sv
// Opcode classifier: one-hot instruction class, with optionally disabled
// instruction groups reported as illegal.
module rv_opcode_class
    import rv_ctrl_pkg::*;
#(
    parameter bit EN_UPPER = 1'b1,
    parameter bit EN_JUMP  = 1'b1
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output op_class_t           class_o,
    output logic                illegal_o
);

    always_comb begin
        class_o = '0;
        case (opcode_i)
            OP_R:      class_o[CLS_R]      = 1'b1;
            OP_I:      class_o[CLS_I]      = 1'b1;
            OP_LOAD:   class_o[CLS_LOAD]   = 1'b1;
            OP_STORE:  class_o[CLS_STORE]  = 1'b1;
            OP_BRANCH: class_o[CLS_BRANCH] = 1'b1;
            OP_JAL:    class_o[CLS_JAL]    = EN_JUMP;
            OP_JALR:   class_o[CLS_JALR]   = EN_JUMP;
            OP_LUI:    class_o[CLS_LUI]    = EN_UPPER;
            OP_AUIPC:  class_o[CLS_AUIPC]  = EN_UPPER;
            default:   class_o             = '0;
        endcase
        illegal_o = ~|class_o;
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB, drives
// datapath selects, handles variable-latency memory with a timeout and traps.
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter bit          EN_UPPER    = 1'b1,
    parameter bit          EN_JUMP     = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                mem_ready_i,
    input  logic                branch_taken_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic                reg_write_o,
    output logic [SEL_W-1:0]    alu_src_a_o,
    output logic [SEL_W-1:0]    alu_src_b_o,
    output logic [SEL_W-1:0]    alu_op_o,
    output logic [SEL_W-1:0]    wb_sel_o,
    output logic                pc_src_o,
    output logic                illegal_instr_o,
    output logic                bus_err_o,
    output logic [STATE_W-1:0]  state_dbg_o
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 32'd0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    op_class_t        cls;
    logic             op_illegal;
    logic             timeout_c;
    ctrl_t            ctrl_c;
    ctrl_t            ctrl_out_c;

    rv_opcode_class #(
        .EN_UPPER (EN_UPPER),
        .EN_JUMP  (EN_JUMP)
    ) u_opcode_class (
        .opcode_i  (opcode_i),
        .class_o   (cls),
        .illegal_o (op_illegal)
    );

    // Timeout fires on the wait cycle that would bring the counter to MEM_TIMEOUT
    assign timeout_c = (MEM_TIMEOUT != 0) && !mem_ready_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        ctrl_c    = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.alu_src_a = SRCA_PC;
                ctrl_c.alu_src_b = SRCB_CONST4;
                ctrl_c.alu_op    = ALU_ADD;
                if (mem_ready_i) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    ctrl_c.pc_src   = PCSRC_ALU;
                    state_d         = S_DECODE;
                end else if (timeout_c) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DECODE: begin
                ctrl_c.alu_src_a = SRCA_OLDPC;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALU_ADD;
                if (op_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d   = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                if (cls[CLS_R]) begin
                    ctrl_c.alu_src_a = SRCA_RS1;
                    ctrl_c.alu_src_b = SRCB_RS2;
                    ctrl_c.alu_op    = ALU_RTYPE;
                    state_d          = S_WB;
                end else if (cls[CLS_I]) begin
                    ctrl_c.alu_src_a = SRCA_RS1;
                    ctrl_c.alu_src_b = SRCB_IMM;
                    ctrl_c.alu_op    = ALU_ITYPE;
                    state_d          = S_WB;
                end else if (cls[CLS_LOAD] || cls[CLS_STORE]) begin
                    ctrl_c.alu_src_a = SRCA_RS1;
                    ctrl_c.alu_src_b = SRCB_IMM;
                    ctrl_c.alu_op    = ALU_ADD;
                    state_d          = S_MEM;
                end else if (cls[CLS_BRANCH]) begin
                    ctrl_c.alu_src_a = SRCA_RS1;
                    ctrl_c.alu_src_b = SRCB_RS2;
                    ctrl_c.alu_op    = ALU_BRANCH;
                    if (branch_taken_i) begin
                        ctrl_c.pc_write = 1'b1;
                        ctrl_c.pc_src   = PCSRC_ALUOUT;
                    end
                end else if (cls[CLS_JAL]) begin
                    ctrl_c.pc_write  = 1'b1;
                    ctrl_c.pc_src    = PCSRC_ALUOUT;
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.wb_sel    = WB_PC;
                end else if (cls[CLS_JALR]) begin
                    ctrl_c.alu_src_a = SRCA_RS1;
                    ctrl_c.alu_src_b = SRCB_IMM;
                    ctrl_c.alu_op    = ALU_ADD;
                    ctrl_c.pc_write  = 1'b1;
                    ctrl_c.pc_src    = PCSRC_ALU;
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.wb_sel    = WB_PC;
                end else if (cls[CLS_LUI]) begin
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.wb_sel    = WB_IMM;
                end else if (cls[CLS_AUIPC]) begin
                    ctrl_c.alu_src_a = SRCA_OLDPC;
                    ctrl_c.alu_src_b = SRCB_IMM;
                    ctrl_c.alu_op    = ALU_ADD;
                    state_d          = S_WB;
                end else begin
                    // opcode changed under us after DECODE: treat as illegal
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_MEM: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.mem_we  = cls[CLS_STORE];
                if (mem_ready_i) begin
                    state_d = cls[CLS_LOAD] ? S_WB : S_FETCH;
                end else if (timeout_c) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.wb_sel    = cls[CLS_LOAD] ? WB_MEMDATA : WB_ALUOUT;
                state_d          = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Wait counter: restarts on every state change, saturates while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready_i
                     && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign ctrl_out_c      = rst_n ? ctrl_c : '0;
    assign mem_req_o       = ctrl_out_c.mem_req;
    assign mem_we_o        = ctrl_out_c.mem_we;
    assign ir_write_o      = ctrl_out_c.ir_write;
    assign pc_write_o      = ctrl_out_c.pc_write;
    assign reg_write_o     = ctrl_out_c.reg_write;
    assign alu_src_a_o     = ctrl_out_c.alu_src_a;
    assign alu_src_b_o     = ctrl_out_c.alu_src_b;
    assign alu_op_o        = ctrl_out_c.alu_op;
    assign wb_sel_o        = ctrl_out_c.wb_sel;
    assign pc_src_o        = ctrl_out_c.pc_src;
    assign illegal_instr_o = rst_n & illegal_q;
    assign bus_err_o       = rst_n & bus_err_q;
    assign state_dbg_o     = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed vector table, timeout/trap sequences and
// random stimulus against an instruction-route reference model, on two configurations.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LD = 7'b0000011;
    localparam logic [6:0] O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111;
    localparam logic [6:0] O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_AUI = 7'b0010111;
    localparam logic [6:0] O_BAD = 7'b1111111;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5;
    localparam int K_JALR = 6, K_LUI = 7, K_AUI = 8, K_ILL = 9;

    typedef logic [18:0] vec_t;
    typedef struct {
        bit rn; logic [6:0] op; bit rdy; bit bt;
        logic [2:0] st; bit req; bit we; bit irw; bit pcw; bit rw;
        logic [1:0] a; logic [1:0] b; logic [1:0] alu; logic [1:0] wb;
        bit pcs; bit ill; bit berr;
    } vec_rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, mem_ready, branch_taken;
    logic [6:0] opcode;
    logic req_a, we_a, irw_a, pcw_a, rw_a, pcs_a, ill_a, berr_a;
    logic [1:0] sa_a, sb_a, op_a, wb_a;
    logic [2:0] st_a;
    logic req_b, we_b, irw_b, pcw_b, rw_b, pcs_b, ill_b, berr_b;
    logic [1:0] sa_b, sb_b, op_b, wb_b;
    logic [2:0] st_b;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(15), .EN_UPPER(1'b1), .EN_JUMP(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .branch_taken_i(branch_taken), .mem_req_o(req_a), .mem_we_o(we_a),
        .ir_write_o(irw_a), .pc_write_o(pcw_a), .reg_write_o(rw_a),
        .alu_src_a_o(sa_a), .alu_src_b_o(sb_a), .alu_op_o(op_a), .wb_sel_o(wb_a),
        .pc_src_o(pcs_a), .illegal_instr_o(ill_a), .bus_err_o(berr_a), .state_dbg_o(st_a));

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(3), .EN_UPPER(1'b0), .EN_JUMP(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .branch_taken_i(branch_taken), .mem_req_o(req_b), .mem_we_o(we_b),
        .ir_write_o(irw_b), .pc_write_o(pcw_b), .reg_write_o(rw_b),
        .alu_src_a_o(sa_b), .alu_src_b_o(sb_b), .alu_op_o(op_b), .wb_sel_o(wb_b),
        .pc_src_o(pcs_b), .illegal_instr_o(ill_b), .bus_err_o(berr_b), .state_dbg_o(st_b));

    vec_t obs_a, obs_b;
    assign obs_a = {st_a, ill_a, berr_a, req_a, we_a, irw_a, pcw_a, rw_a, sa_a, sb_a, op_a, wb_a, pcs_a};
    assign obs_b = {st_b, ill_b, berr_b, req_b, we_b, irw_b, pcw_b, rw_b, sa_b, sb_b, op_b, wb_b, pcs_b};

    int checks = 0;
    int errors = 0;

    // Reference model: each instruction walks a route of phases chosen by its class
    int m_pos[2], m_cls[2], m_wcnt[2];
    bit m_ill[2], m_berr[2], m_trap[2];
    int m_tmo[2] = '{15, 3};
    bit m_eu[2]  = '{1'b1, 1'b0};
    bit m_ej[2]  = '{1'b1, 1'b0};

    function automatic int classify(logic [6:0] op, bit eu, bit ej);
        case (op)
            O_R:    return K_R;
            O_I:    return K_I;
            O_LD:   return K_LD;
            O_ST:   return K_ST;
            O_BR:   return K_BR;
            O_JAL:  return ej ? K_JAL : K_ILL;
            O_JALR: return ej ? K_JALR : K_ILL;
            O_LUI:  return eu ? K_LUI : K_ILL;
            O_AUI:  return eu ? K_AUI : K_ILL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int route_len(int c);
        if (c == K_LD) return 5;
        if (c == K_R || c == K_I || c == K_AUI || c == K_ST) return 4;
        return 3;
    endfunction

    // Phase numbers are the documented state_dbg values
    function automatic int phase_of(int m);
        if (m_trap[m]) return 7;
        if (m_pos[m] == 3) return (m_cls[m] == K_LD || m_cls[m] == K_ST) ? 3 : 4;
        if (m_pos[m] == 4) return 4;
        return m_pos[m];
    endfunction

    function automatic vec_t expect_vec(int m, bit rn, bit rdy, bit bt);
        bit req = 0, we = 0, irw = 0, pcw = 0, rw = 0, pcs = 0;
        logic [1:0] a = 0, b = 0, alu = 0, wb = 0;
        int ph;
        if (!rn) return '0;
        ph = phase_of(m);
        case (ph)
            0: begin req = 1; b = 2; if (rdy) begin irw = 1; pcw = 1; end end
            1: begin a = 1; b = 1; end
            2: case (m_cls[m])
                K_R:        begin a = 2; b = 0; alu = 2; end
                K_I:        begin a = 2; b = 1; alu = 3; end
                K_LD, K_ST: begin a = 2; b = 1; end
                K_BR:       begin a = 2; b = 0; alu = 1; pcw = bt; pcs = bt; end
                K_JAL:      begin pcw = 1; pcs = 1; rw = 1; wb = 2; end
                K_JALR:     begin a = 2; b = 1; pcw = 1; rw = 1; wb = 2; end
                K_LUI:      begin rw = 1; wb = 3; end
                K_AUI:      begin a = 1; b = 1; end
                default:    ;
            endcase
            3: begin req = 1; we = (m_cls[m] == K_ST); end
            4: begin rw = 1; wb = (m_cls[m] == K_LD) ? 2'd1 : 2'd0; end
            default: ;
        endcase
        return {3'(ph), m_ill[m], m_berr[m], req, we, irw, pcw, rw, a, b, alu, wb, pcs};
    endfunction

    task automatic advance(int m);
        m_pos[m] = m_pos[m] + 1;
        if (m_pos[m] >= route_len(m_cls[m])) m_pos[m] = 0;
        m_wcnt[m] = 0;
    endtask

    task automatic model_step(int m, bit rn, logic [6:0] op, bit rdy);
        int ph, c;
        if (!rn) begin
            m_pos[m] = 0; m_wcnt[m] = 0; m_ill[m] = 0; m_berr[m] = 0; m_trap[m] = 0;
            return;
        end
        if (m_trap[m]) return;
        ph = phase_of(m);
        if (ph == 0 || ph == 3) begin
            if (rdy) advance(m);
            else if (m_tmo[m] > 0 && m_wcnt[m] == m_tmo[m] - 1) begin
                m_berr[m] = 1; m_trap[m] = 1;
            end else m_wcnt[m] = m_wcnt[m] + 1;
        end else if (ph == 1) begin
            c = classify(op, m_eu[m], m_ej[m]);
            if (c == K_ILL) begin m_ill[m] = 1; m_trap[m] = 1; end
            else begin m_cls[m] = c; advance(m); end
        end else advance(m);
    endtask

    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(bit rn, logic [6:0] op, bit rdy, bit bt);
        rst_n = rn; opcode = op; mem_ready = rdy; branch_taken = bt;
        @(negedge clk);
        check_val("model_a", 32'(obs_a), 32'(expect_vec(0, rn, rdy, bt)));
        check_val("model_b", 32'(obs_b), 32'(expect_vec(1, rn, rdy, bt)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, rst_n, opcode, mem_ready);
        model_step(1, rst_n, opcode, mem_ready);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, O_R, 1'b1, 1'b0);
        tick();
    endtask

    function automatic vec_t pack_rec(vec_rec_t r);
        return {r.st, r.ill, r.berr, r.req, r.we, r.irw, r.pcw, r.rw, r.a, r.b, r.alu, r.wb, r.pcs};
    endfunction

    function automatic vec_rec_t rf(logic [6:0] op);
        return '{1, op, 1, 0, 3'd0, 1, 0, 1, 1, 0, 2'd0, 2'd2, 2'd0, 2'd0, 0, 0, 0};
    endfunction

    function automatic vec_rec_t rd(logic [6:0] op);
        return '{1, op, 1, 0, 3'd1, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 2'd0, 0, 0, 0};
    endfunction

    vec_rec_t tbl[36];
    logic [6:0] pool[11];

    initial begin
        rst_n = 1'b0; opcode = O_R; mem_ready = 1'b0; branch_taken = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_pos[m] = 0; m_cls[m] = K_R; m_wcnt[m] = 0;
            m_ill[m] = 0; m_berr[m] = 0; m_trap[m] = 0;
        end
        tbl[0]  = '{0, O_R, 1, 0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0};
        tbl[1]  = rf(O_R);  tbl[2] = rd(O_R);
        tbl[3]  = '{1, O_R, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0, 0, 0, 0};
        tbl[4]  = '{1, O_R, 1, 0, 3'd4, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0};
        tbl[5]  = rf(O_I);  tbl[6] = rd(O_I);
        tbl[7]  = '{1, O_I, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd3, 2'd0, 0, 0, 0};
        tbl[8]  = '{1, O_I, 1, 0, 3'd4, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0};
        tbl[9]  = rf(O_LD); tbl[10] = rd(O_LD);
        tbl[11] = '{1, O_LD, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0};
        for (int i = 12; i < 15; i++)
            tbl[i] = '{1, O_LD, 0, 0, 3'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0};
        tbl[15] = '{1, O_LD, 1, 0, 3'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0};
        tbl[16] = '{1, O_LD, 1, 0, 3'd4, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd1, 0, 0, 0};
        tbl[17] = rf(O_BR); tbl[18] = rd(O_BR);
        tbl[19] = '{1, O_BR, 1, 1, 3'd2, 0, 0, 0, 1, 0, 2'd2, 2'd0, 2'd1, 2'd0, 1, 0, 0};
        tbl[20] = rf(O_BR); tbl[21] = rd(O_BR);
        tbl[22] = '{1, O_BR, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd1, 2'd0, 0, 0, 0};
        tbl[23] = rf(O_JAL); tbl[24] = rd(O_JAL);
        tbl[25] = '{1, O_JAL, 1, 0, 3'd2, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 2'd2, 1, 0, 0};
        tbl[26] = rf(O_ST); tbl[27] = rd(O_ST);
        tbl[28] = '{1, O_ST, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0};
        tbl[29] = '{1, O_ST, 1, 0, 3'd3, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0};
        tbl[30] = rf(O_BAD); tbl[31] = rd(O_BAD);
        tbl[32] = '{1, O_BAD, 1, 0, 3'd7, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 1, 0};
        tbl[33] = tbl[32];
        tbl[34] = '{0, O_BAD, 1, 0, 3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0};
        tbl[35] = rf(O_R);
        pool = '{O_R, O_I, O_LD, O_ST, O_BR, O_JAL, O_JALR, O_LUI, O_AUI, O_BAD, 7'b0000000};

        @(posedge clk); #1;

        for (int i = 0; i < 36; i++) begin
            drive(tbl[i].rn, tbl[i].op, tbl[i].rdy, tbl[i].bt);
            check_val($sformatf("tbl[%0d]", i), 32'(obs_a), 32'(pack_rec(tbl[i])));
            tick();
        end

        // Timeout: 15th consecutive wait cycle in FETCH traps with bus_err
        do_reset();
        for (int k = 0; k < 14; k++) begin drive(1, O_R, 0, 0); tick(); end
        drive(1, O_R, 0, 0);
        check_val("timeout_pre", {28'd0, st_a, berr_a}, {28'd0, 3'd0, 1'b0});
        tick();
        drive(1, O_R, 0, 0);
        check_val("timeout_trap", {28'd0, st_a, berr_a}, {28'd0, 3'd7, 1'b1});
        tick();

        // mem_ready on the timeout cycle wins
        do_reset();
        for (int k = 0; k < 14; k++) begin drive(1, O_R, 0, 0); tick(); end
        drive(1, O_R, 1, 0); tick();
        drive(1, O_R, 1, 0);
        check_val("timeout_ready_wins", {28'd0, st_a, berr_a}, {28'd0, 3'd1, 1'b0});
        tick();

        // LUI traps when upper-immediate instructions are disabled
        do_reset();
        drive(1, O_LUI, 1, 0); tick();
        drive(1, O_LUI, 1, 0); tick();
        drive(1, O_LUI, 1, 0);
        check_val("lui_trap_b", {28'd0, st_b, ill_b}, {28'd0, 3'd7, 1'b1});
        check_val("lui_exec_a", {26'd0, st_a, rw_a, wb_a}, {26'd0, 3'd2, 1'b1, 2'd3});
        tick();
        do_reset();
        drive(1, O_LUI, 1, 0);
        check_val("lui_clear_b", {28'd0, st_b, ill_b}, {28'd0, 3'd0, 1'b0});
        tick();

        // Random traffic; opcode only changes in FETCH, reset after any trap
        for (int n = 0; n < 3000; n++) begin
            bit rn;
            logic [6:0] op;
            rn = !(m_trap[0] || m_trap[1]);
            op = opcode;
            if (phase_of(0) == 0) op = pool[$urandom_range(10, 0)];
            drive(rn, op, $urandom_range(3, 0) != 0, 1'($urandom_range(1, 0)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
